// File: rtl/icache_pkg.sv
// Line geometry and refill FSM encoding shared by instr_cache_L1 and icache_line_server.
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int WORD_BITS  = 32;
  localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;
  localparam int WORD_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fill_state_e;

endpackage

// File: rtl/icache_line_server.sv
// Serves an L1 I-cache line fill by reading 8 words, one at a time, from a 32-bit
// backing port and returning the assembled 256-bit line with a one-cycle mem_valid.
module icache_line_server
  import icache_pkg::*;
#(
  parameter int BK_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 mem_req,
  input  logic [31:0]          mem_address,
  output logic [LINE_BITS-1:0] mem_data,
  output logic                 mem_valid,
  output logic                 bk_rd_en,
  output logic [31:0]          bk_addr,
  input  logic [31:0]          bk_rd_data,
  input  logic                 bk_rd_valid,
  output logic                 bk_err
);

  localparam int TMR_W = $clog2(BK_TIMEOUT + 1);
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(LINE_WORDS - 1);

  fill_state_e state, state_nxt;
  logic [WORD_IDX_W-1:0] count, count_nxt;
  logic [31:0]           base, base_nxt;
  logic [TMR_W-1:0]      tmr, tmr_nxt;
  logic                  err_nxt;
  logic                  served, served_nxt;
  logic [31:0]           served_base, served_base_nxt;
  logic                  cap;
  logic [31:0]           req_base;
  logic                  armed;

  logic [LINE_WORDS-1:0][WORD_BITS-1:0] line_q;

  // Line-aligned word address; the low three bits never participate in a fill.
  assign req_base = mem_address & ~32'h7;
  // The cache keeps mem_req high after a fill, so only a new line address re-arms.
  assign armed    = !served || (req_base != served_base);

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    base_nxt        = base;
    tmr_nxt         = tmr;
    err_nxt         = bk_err;
    served_nxt      = served;
    served_base_nxt = served_base;
    cap             = 1'b0;
    if (!mem_req) served_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && armed) begin
          base_nxt  = req_base;
          count_nxt = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmr_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bk_rd_valid) begin
          cap = 1'b1;
          if (count == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            count_nxt = count + 1'b1;
            state_nxt = ISSUE;
          end
        end else if (tmr == TMR_W'(BK_TIMEOUT)) begin
          // Retry the same word; the error stays flagged until reset.
          err_nxt   = 1'b1;
          state_nxt = ISSUE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      DONE: begin
        served_nxt      = 1'b1;
        served_base_nxt = base;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      count       <= '0;
      base        <= '0;
      tmr         <= '0;
      bk_err      <= 1'b0;
      served      <= 1'b0;
      served_base <= '0;
      mem_valid   <= 1'b0;
      bk_rd_en    <= 1'b0;
      bk_addr     <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      base        <= base_nxt;
      tmr         <= tmr_nxt;
      bk_err      <= err_nxt;
      served      <= served_nxt;
      served_base <= served_base_nxt;
      mem_valid   <= (state_nxt == DONE);
      bk_rd_en    <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE) bk_addr <= base_nxt + 32'(count_nxt);
    end
  end

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_slot
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                                  line_q[w] <= '0;
      else if (cap && count == WORD_IDX_W'(w))     line_q[w] <= bk_rd_data;
    end
  end

  assign mem_data = line_q;

endmodule
